// File: rtl/rain_bcd_converter.sv
// rain_bcd_converter: scales rain-gauge pulses to 0.01 mm and converts to five BCD digits,
// saturating at 999.99 mm.
module rain_bcd_converter #(
   parameter int PULSE_HUNDREDTHS = 20,
   parameter int IN_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] pulses,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            overflow,
   output logic [3:0]      hundreds_bcd,
   output logic [3:0]      tens_bcd,
   output logic [3:0]      units_bcd,
   output logic [3:0]      tenths_bcd,
   output logic [3:0]      hundredths_bcd
);
   typedef enum logic [2:0] {IDLE, MUL, SAT, CONV, DONE} state_t;
   localparam int AW = IN_W + 5;
   localparam int CW = $clog2(IN_W > 17 ? IN_W : 17);
   state_t          state;
   logic [IN_W-1:0] op;
   logic [AW-1:0]   acc;
   logic [16:0]     bin;
   logic [19:0]     bcd, adj;
   logic [CW-1:0]   cnt;
   logic            ovf_p;
   // double-dabble correction applied before each shift
   always_comb begin
      adj = bcd;
      for (int i = 0; i < 5; i++)
         adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op <= '0;
         acc <= '0;
         bin <= '0;
         bcd <= '0;
         cnt <= '0;
         ovf_p <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         overflow <= 1'b0;
         hundreds_bcd <= '0;
         tens_bcd <= '0;
         units_bcd <= '0;
         tenths_bcd <= '0;
         hundredths_bcd <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op <= pulses;
               acc <= '0;
               cnt <= '0;
               busy <= 1'b1;
               state <= MUL;
            end
            MUL: begin
               if (op[0]) acc <= acc + (AW'(PULSE_HUNDREDTHS) << cnt);
               op <= op >> 1;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(IN_W - 1)) begin
                  cnt <= '0;
                  state <= SAT;
               end
            end
            SAT: begin
               ovf_p <= acc > AW'(99999);
               bin <= (acc > AW'(99999)) ? 17'd99999 : 17'(acc);
               bcd <= '0;
               state <= CONV;
            end
            CONV: begin
               bcd <= {adj[18:0], bin[16]};
               bin <= bin << 1;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(16)) state <= DONE;
            end
            DONE: begin
               hundreds_bcd <= bcd[19:16];
               tens_bcd <= bcd[15:12];
               units_bcd <= bcd[11:8];
               tenths_bcd <= bcd[7:4];
               hundredths_bcd <= bcd[3:0];
               overflow <= ovf_p;
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rain_bcd_converter.sv
// tb_rain_bcd_converter: arithmetic reference model with per-cycle compare plus directed
// vectors with literal expectations.
module tb_rain_bcd_converter;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [15:0] pulses = '0;
   logic        busy, done, overflow;
   logic [3:0]  h, t, u, te, hu;
   int          total = 0, bad = 0, done_cnt = 0, cyc = 0;
   bit          chk_en = 1'b0;
   bit          m_active = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
   int          m_cnt = 0, m_val = 0;
   logic [19:0] m_dig = '0;

   rain_bcd_converter #(.PULSE_HUNDREDTHS(20), .IN_W(16)) dut (
      .clk(clk), .rst(rst), .pulses(pulses), .start(start),
      .busy(busy), .done(done), .overflow(overflow),
      .hundreds_bcd(h), .tens_bcd(t), .units_bcd(u),
      .tenths_bcd(te), .hundredths_bcd(hu)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [19:0] to_digits(input int v);
      int s;
      s = (v > 99999) ? 99999 : v;
      return {4'(s / 10000), 4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   // reference: accepted start -> result visible 35 clocks later
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_active = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_dig = '0;
      end else begin
         m_done = 1'b0;
         if (!m_active && start) begin
            m_active = 1'b1; m_cnt = 0; m_val = int'(pulses) * 20;
         end else if (m_active) begin
            m_cnt++;
            if (m_cnt == 35) begin
               m_active = 1'b0; m_done = 1'b1;
               m_dig = to_digits(m_val); m_ovf = m_val > 99999;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (chk_en) begin
         check("busy", int'(busy), int'(m_active));
         check("done", int'(done), int'(m_done));
         check("overflow", int'(overflow), int'(m_ovf));
         check("digits", int'({h, t, u, te, hu}), int'(m_dig));
      end
   end

   task automatic run(input int p, input logic [19:0] exp, input bit eo);
      int n;
      @(negedge clk);
      pulses = 16'(p);
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start = 1'b0;
      end while (!done && n < 80);
      check("latency", n, 36);
      check("lit_digits", int'({h, t, u, te, hu}), int'(exp));
      check("lit_ovf", int'(overflow), int'(eo));
      @(negedge clk);
   endtask

   initial begin
      int d0, k, n;
      int times[3];
      @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      start = 1'b1;
      pulses = 16'd50;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_digits", int'({h, t, u, te, hu}), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("no_conv_after_rst", int'(busy), 0);

      run(0, 20'h00000, 1'b0);
      run(1, 20'h00020, 1'b0);
      run(4999, 20'h99980, 1'b0);
      run(5000, 20'h99999, 1'b1);
      run(65535, 20'h99999, 1'b1);
      run(1234, 20'h24680, 1'b0);

      // input change and extra start while busy
      @(negedge clk);
      pulses = 16'd1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      pulses = 16'd77;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      check("one_done", done_cnt - d0, 1);
      check("busy_ignored", int'({h, t, u, te, hu}), int'(20'h24680));

      // held start: back-to-back conversions
      @(negedge clk);
      pulses = 16'd10;
      start = 1'b1;
      k = 0;
      n = 0;
      while (k < 3 && n < 200) begin
         @(negedge clk);
         n++;
         if (done) begin
            times[k] = cyc;
            k++;
         end
      end
      start = 1'b0;
      check("held_dones", k, 3);
      check("period1", times[1] - times[0], 36);
      check("period2", times[2] - times[1], 36);
      check("held_digits", int'({h, t, u, te, hu}), int'(20'h00200));
      repeat (40) @(negedge clk);

      // reset mid-conversion
      pulses = 16'd300;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_digits", int'({h, t, u, te, hu}), 0);
      rst = 1'b0;
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      check("no_done_after_rst", done_cnt - d0, 0);
      run(300, 20'h06000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
